// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache controller: FSM state encoding,
// line geometry and address field offsets.
package dcache_pkg;

  // Controller states: lookup, write-back of a dirty victim, refill, and one
  // settle cycle before the re-lookup.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Line geometry: 8 x 32-bit words per 32-byte line.
  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;
  localparam int WORD_SEL_W = 3;

  // Byte-address field offsets: word select starts at bit 2, index at bit 5.
  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = 5;

  // Extract one 32-bit word from a line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                  input logic [WORD_SEL_W-1:0] sel);
    return line[{sel, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the direct-mapped cache: valid/dirty bits (async reset),
// tag and data arrays (no reset). One async read port addressed by index,
// one sync write port that either fills a whole line (refill) or updates a
// single word (store hit).
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [LINE_W-1:0]     line_o,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_W-1:0]     line_data_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // Asynchronous read of the indexed line.
  always_comb begin
    valid_o = valid_q[idx_i];
    dirty_o = dirty_q[idx_i];
    tag_o   = tag_mem[idx_i];
    line_o  = data_mem[idx_i];
  end

  // Line state: a refill makes the line valid and clean, a store marks it dirty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: full-line refill or single-word store.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_mem[idx_i]  <= line_tag_i;
      data_mem[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_mem[idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the
// MEM stage. Stalls the pipeline while a dirty victim is written back and the
// missing line is refilled over a req/ack memory interface.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters
// (hit_cnt_o, miss_cnt_o).
//
// Memory handshake: mem_req_o together with mem_we_o, mem_addr_o and
// mem_data_o stays asserted and stable from the first request cycle up to and
// including the cycle in which mem_ack_i is sampled high; the transfer
// completes on that edge and the request drops (or moves on to the refill)
// in the following cycle. mem_ack_i is ignored whenever mem_req_o is low.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_LSB - IDX_W;

  state_t state;
  state_t state_next;

  logic [WORD_SEL_W-1:0] word;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;

  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_W-1:0]     line_data;

  logic                  hit;
  logic                  line_we;
  logic                  word_we;

  // Byte offset bits are always zero for word-aligned accesses.
  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr_i[WORD_LSB-1:0];

  // Address split into word select, index and tag.
  always_comb begin
    word = cpu_addr_i[WORD_LSB +: WORD_SEL_W];
    idx  = cpu_addr_i[IDX_LSB +: IDX_W];
    tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
  end

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data),
    .line_we_i   (line_we),
    .line_tag_i  (tag),
    .line_data_i (mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (word),
    .word_data_i (cpu_data_i)
  );

  // Hit detection, load data mux and stall; lookups only happen in IDLE.
  always_comb begin
    hit         = (state == IDLE) && cpu_req_i && line_valid && (line_tag == tag);
    cpu_data_o  = hit ? line_word(line_data, word) : '0;
    cpu_stall_o = (state != IDLE) || (cpu_req_i && !hit);
  end

  // State register; reset abandons any in-flight memory transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, memory request and array write enables.
  always_comb begin
    state_next = state;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    line_we    = 1'b0;
    word_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            word_we = cpu_we_i;
          end else if (line_valid && line_dirty) begin
            state_next = WB;
          end else begin
            state_next = RD;
          end
        end
      end
      WB: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {line_tag, idx, {IDX_LSB{1'b0}}};
        mem_data_o = line_data;
        if (mem_ack_i) begin
          state_next = RD;
        end
      end
      RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, idx, {IDX_LSB{1'b0}}};
        if (mem_ack_i) begin
          line_we    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  // Set for the IDLE cycle right after a refill, whose re-lookup hit belongs
  // to an access already counted as a miss.
  logic was_done;

  // Saturating per-access hit/miss counters, sampled at the IDLE lookup.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      was_done   <= 1'b0;
    end else begin
      was_done <= (state == DONE);
      if ((state == IDLE) && cpu_req_i) begin
        if (hit) begin
          if (!was_done && (hit_cnt_o != 32'hFFFF_FFFF)) begin
            hit_cnt_o <= hit_cnt_o + 32'd1;
          end
        end else if (miss_cnt_o != 32'hFFFF_FFFF) begin
          miss_cnt_o <= miss_cnt_o + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of CPU accesses with expected
// stall lengths, a backing-memory responder with programmable ack latency,
// a load-data scoreboard, and hand-written reset / spurious-ack sequences.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  dcache_ctrl #(.NUM_LINES(16), .ADDR_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_data_i  (cpu_wdata),
    .cpu_data_o  (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata),
    .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / models ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  ref_mem [logic [31:0]];  // architectural view (all stores)
  logic [31:0]  bk_mem  [logic [31:0]];  // backing memory contents
  logic         txn_we_q[$];
  logic [31:0]  txn_addr_q[$];
  logic [255:0] last_wb;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bk_read(input logic [31:0] a);
    return bk_mem.exists(a) ? bk_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver: one CPU access incl. memory responder ----------------
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int delay, output int stall_cycles);
    int          req_cnt;
    int          guard;
    bit          done;
    logic [31:0] held_addr;
    logic [31:0] exp;
    stall_cycles = 0;
    req_cnt      = 0;
    guard        = 0;
    done         = 0;
    held_addr    = '0;
    cpu_req      = 1'b1;
    cpu_we       = we;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    if (!we) exp_q.push_back(ref_read(addr));
    while (!done && guard < 500) begin
      @(negedge clk);
      guard++;
      mem_ack = 1'b0;
      if (!cpu_stall) begin
        done = 1;
        if (!we) begin
          exp = exp_q.pop_front();
          check("load_data", cpu_rdata, exp);
        end else begin
          ref_mem[addr] = wdata;
        end
      end else begin
        stall_cycles++;
        if (mem_req) begin
          if (req_cnt == 0) held_addr = mem_addr;
          else check("req_addr_stable", mem_addr, held_addr);
          req_cnt++;
          if (req_cnt >= delay) begin
            txn_we_q.push_back(mem_we);
            txn_addr_q.push_back(mem_addr);
            if (mem_we) begin
              check("wb_aligned", mem_addr[4:0], 5'd0);
              for (int w = 0; w < 8; w++) begin
                check("wb_word", mem_wdata[w*32 +: 32], ref_read(mem_addr + 32'(w*4)));
                bk_mem[mem_addr + 32'(w*4)] = mem_wdata[w*32 +: 32];
              end
              last_wb = mem_wdata;
            end else begin
              for (int w = 0; w < 8; w++) begin
                mem_rdata[w*32 +: 32] = bk_read(mem_addr + 32'(w*4));
              end
            end
            mem_ack = 1'b1;
            req_cnt = 0;
          end
        end
      end
    end
    if (!done) begin
      check("access_timeout", 1'b0, 1'b1);
      if (!we) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          exp_stall;
  } vec_t;

  vec_t tbl[16];

  task automatic run_rows(input int lo, input int hi);
    int sc;
    for (int i = lo; i <= hi; i++) begin
      cpu_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].delay, sc);
      check($sformatf("stall_cycles[%0d]", i), sc, tbl[i].exp_stall);
    end
    go_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sc;
    int guard;
    //            we    addr            wdata          delay stall
    tbl[0]  = '{1'b0, 32'h0000_0040, 32'h0,          1,  3};  // cold clean miss
    tbl[1]  = '{1'b1, 32'h0000_0044, 32'h1234_5678,  1,  0};  // store hit
    tbl[2]  = '{1'b0, 32'h0000_0044, 32'h0,          1,  0};  // load back
    tbl[3]  = '{1'b0, 32'h0000_0240, 32'h0,          1,  4};  // dirty victim
    tbl[4]  = '{1'b0, 32'h0000_0244, 32'h0,          1,  0};  // hit in new line
    tbl[5]  = '{1'b0, 32'h0000_0048, 32'h0,          1,  3};  // clean victim
    tbl[6]  = '{1'b1, 32'h0000_1080, 32'hA5A5_0001,  2,  4};  // store miss allocate
    tbl[7]  = '{1'b0, 32'h0000_1080, 32'h0,          1,  0};
    tbl[8]  = '{1'b1, 32'h0000_2084, 32'h5A5A_0002,  3,  8};  // WB + RD, 3-cycle acks
    tbl[9]  = '{1'b0, 32'h0000_1080, 32'h0,          1,  4};  // store data via memory
    tbl[10] = '{1'b0, 32'h0000_2084, 32'h0,          1,  3};
    tbl[11] = '{1'b1, 32'h7FFC_FFFC, 32'hFFFF_0003,  1,  3};  // last index, last word
    tbl[12] = '{1'b0, 32'h7FFC_FFFC, 32'h0,          1,  0};
    tbl[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          1,  4};  // all-ones tag
    tbl[14] = '{1'b0, 32'h7FFC_FFFC, 32'h0,          1,  3};
    tbl[15] = '{1'b0, 32'h0000_5000, 32'h0,         10, 12};  // ack latency 10

    bk_mem[32'h40]  = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    last_wb   = '0;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // Reset state.
    #1;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_data", mem_wdata, 256'h0);
    check("rst_cpu_data", cpu_rdata, 32'h0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Miss visible in the same cycle as the request.
    cpu_req  = 1'b1;
    cpu_addr = 32'h40;
    #1;
    check("miss_stall_same_cycle", cpu_stall, 1'b1);
    check("miss_no_req_yet", mem_req, 1'b0);

    run_rows(0, 3);

    // Transfers so far: RD 0x40, then WB 0x40 and RD 0x240.
    check("txn_count", txn_addr_q.size(), 3);
    if (txn_addr_q.size() == 3) begin
      check("txn0_addr", txn_addr_q[0], 32'h40);
      check("txn0_we", txn_we_q[0], 1'b0);
      check("txn1_addr", txn_addr_q[1], 32'h40);
      check("txn1_we", txn_we_q[1], 1'b1);
      check("txn2_addr", txn_addr_q[2], 32'h240);
      check("txn2_we", txn_we_q[2], 1'b0);
    end
    check("wb_word0", last_wb[31:0], 32'hDEAD_BEEF);
    check("wb_word1", last_wb[63:32], 32'h1234_5678);
`ifdef DCACHE_STATS_EN
    check("stats_hit_cnt", hit_cnt, 32'd2);
    check("stats_miss_cnt", miss_cnt, 32'd2);
`endif

    // Spurious ack while idle changes nothing.
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("spurious_mem_req", mem_req, 1'b0);
    check("spurious_stall", cpu_stall, 1'b0);
`ifdef DCACHE_STATS_EN
    check("spurious_hit_cnt", hit_cnt, 32'd2);
    check("spurious_miss_cnt", miss_cnt, 32'd2);
`endif
    @(posedge clk);
    #1;

    run_rows(4, 15);

    // Reset in the middle of a refill.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_3040;
    guard    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(mem_req && !mem_we) && guard < 50);
    check("rd_before_reset", mem_req && !mem_we, 1'b1);
    check("rd_before_reset_addr", mem_addr, 32'h0000_3040);
    rst     = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_stall", cpu_stall, 1'b0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem = bk_mem;
`ifdef DCACHE_STATS_EN
    check("midrst_hit_cnt", hit_cnt, 32'd0);
    check("midrst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    cpu_access(1'b0, 32'h40, 32'h0, 1, sc);
    check("reload_after_reset_stall", sc, 3);
    go_idle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
